// File: rtl/shift_left_logical_seq_pkg.sv
// Shared types and helpers for the multi-cycle logical left shifter.
package shift_pkg;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_e;

  localparam int WIDTH_DEF = 32;

  function automatic logic [31:0] min_step(input logic [31:0] remaining,
                                           input logic [31:0] step);
    return (remaining < step) ? remaining : step;
  endfunction

endpackage

// File: rtl/shift_left_logical_seq_if.sv
// Request/response bundle between the ALU sequencer and the shifter.
interface shift_left_logical_seq_if #(parameter int WIDTH = shift_pkg::WIDTH_DEF);
  logic             start;
  logic [WIDTH-1:0] X;
  logic [31:0]      Y;
  logic [31:0]      i;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] Z;
  logic             Zi;

  modport master (output start, X, Y, i, input busy, done, Z, Zi);
  modport slave  (input start, X, Y, i, output busy, done, Z, Zi);
endinterface

// File: rtl/shift_left_logical_seq_step.sv
// One combinational shift stage; kept separate so an arithmetic variant can swap the fill.
module shift_left_step #(
  parameter int WIDTH = shift_pkg::WIDTH_DEF,
  parameter int KW    = $clog2(WIDTH) + 1
) (
  input  logic [WIDTH-1:0] acc_i,
  input  logic [KW-1:0]    k_i,
  output logic [WIDTH-1:0] acc_o
);
  assign acc_o = acc_i << k_i;
endmodule

// File: rtl/shift_left_logical_seq.sv
// Multi-cycle logical left shifter: up to STEP bits per clock, start/done handshake.
module shift_left_logical_seq
  import shift_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int STEP  = 1
) (
  input logic clk,
  input logic rst,
  shift_left_logical_seq_if.slave bus
);
  localparam int KW = $clog2(WIDTH) + 1;
  localparam int IW = $clog2(WIDTH);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d, acc_sh;
  logic [WIDTH-1:0] z_q, z_d;
  logic [31:0]      rem_q, rem_d, k_full;
  logic [KW-1:0]    k;

  // In SHIFT rem_q < WIDTH, so k always fits in KW bits.
  assign k_full = min_step(rem_q, 32'(STEP));
  assign k      = k_full[KW-1:0];

  shift_left_step #(.WIDTH(WIDTH), .KW(KW)) u_step (
    .acc_i (acc_q),
    .k_i   (k),
    .acc_o (acc_sh)
  );

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    rem_d   = rem_q;
    case (state_q)
      IDLE: if (bus.start) begin
        acc_d = bus.X;
        rem_d = bus.Y;
        if (bus.Y >= 32'(WIDTH)) begin
          acc_d   = '0;
          state_d = DONE;
        end else if (bus.Y == 32'd0) begin
          state_d = DONE;
        end else begin
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        acc_d = acc_sh;
        rem_d = rem_q - k_full;
        if (rem_d == 32'd0) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Z captures the final accumulator on the edge that enters DONE.
  assign z_d = (state_d == DONE && state_q != DONE) ? acc_d : z_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      acc_q   <= '0;
      rem_q   <= '0;
      z_q     <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      rem_q   <= rem_d;
      z_q     <= z_d;
    end
  end

  assign bus.busy = (state_q != IDLE);
  assign bus.done = (state_q == DONE);
  assign bus.Z    = z_q;
  assign bus.Zi   = (bus.i < 32'(WIDTH)) ? z_q[bus.i[IW-1:0]] : 1'b0;

endmodule

// File: tb/tb_shift_left_logical_seq.sv
// Directed bench for the left shifter: STEP=1 and STEP=4 instances against a latency/result model.
module tb_shift_left_logical_seq;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  shift_left_logical_seq_if #(.WIDTH(32)) b1 ();
  shift_left_logical_seq_if #(.WIDTH(32)) b4 ();

  shift_left_logical_seq #(.WIDTH(32), .STEP(1)) u1 (.clk(clk), .rst(rst), .bus(b1));
  shift_left_logical_seq #(.WIDTH(32), .STEP(4)) u4 (.clk(clk), .rst(rst), .bus(b4));

  logic [1:0]  s_start;
  logic [31:0] s_x [2];
  logic [31:0] s_y [2];
  logic [31:0] s_i [2];
  logic [1:0]  o_busy, o_done, o_zi;
  logic [31:0] o_z [2];

  assign b1.start = s_start[0]; assign b1.X = s_x[0]; assign b1.Y = s_y[0]; assign b1.i = s_i[0];
  assign b4.start = s_start[1]; assign b4.X = s_x[1]; assign b4.Y = s_y[1]; assign b4.i = s_i[1];
  assign o_busy = {b4.busy, b1.busy};
  assign o_done = {b4.done, b1.done};
  assign o_zi   = {b4.Zi, b1.Zi};
  assign o_z[0] = b1.Z;
  assign o_z[1] = b4.Z;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%h exp=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  function automatic int lat_of(input logic [31:0] y, input int step);
    if (y == 0 || y >= 32) return 1;
    return 1 + (int'(y) + step - 1) / step;
  endfunction

  function automatic logic [31:0] res_of(input logic [31:0] x, input logic [31:0] y);
    if (y >= 32) return 32'd0;
    return x << y;
  endfunction

  // Model: cycles left in the busy window (last one is the done cycle) and the visible Z.
  int          m_left [2];
  logic [31:0] m_z    [2];
  logic [31:0] m_pend [2];

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < 2; k++) begin
        m_left[k] <= 0;
        m_z[k]    <= '0;
        m_pend[k] <= '0;
      end
    end else begin
      for (int k = 0; k < 2; k++) begin
        if (m_left[k] == 0) begin
          if (s_start[k]) begin
            m_left[k] <= lat_of(s_y[k], (k == 1) ? 4 : 1);
            m_pend[k] <= res_of(s_x[k], s_y[k]);
            if (lat_of(s_y[k], (k == 1) ? 4 : 1) == 1) m_z[k] <= res_of(s_x[k], s_y[k]);
          end
        end else begin
          if (m_left[k] == 2) m_z[k] <= m_pend[k];
          m_left[k] <= m_left[k] - 1;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      for (int k = 0; k < 2; k++) begin
        chk($sformatf("busy%0d", k), 32'(o_busy[k]), 32'(m_left[k] != 0));
        chk($sformatf("done%0d", k), 32'(o_done[k]), 32'(m_left[k] == 1));
        chk($sformatf("Z%0d", k), o_z[k], m_z[k]);
        chk($sformatf("Zi%0d", k), 32'(o_zi[k]), (s_i[k] >= 32) ? 32'd0 : 32'(m_z[k][s_i[k][4:0]]));
      end
    end
  end

  // Issue one op on instance k and check latency, Z and Zi against hand values.
  task automatic run_op(input int k, input logic [31:0] x, input logic [31:0] y,
                        input logic [31:0] idx, input logic [31:0] exp_z,
                        input int exp_lat, input logic exp_zi);
    int cyc;
    @(negedge clk);
    s_x[k] = x; s_y[k] = y; s_i[k] = idx; s_start[k] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    s_start[k] = 1'b0;
    cyc = 1;
    while (!o_done[k] && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    chk($sformatf("lat y=%0d", y), 32'(cyc), 32'(exp_lat));
    chk($sformatf("Zlit y=%0d", y), o_z[k], exp_z);
    chk($sformatf("Zilit y=%0d i=%0d", y, idx), 32'(o_zi[k]), 32'(exp_zi));
    @(negedge clk);
    chk("done single", 32'(o_done[k]), 32'd0);
  endtask

  initial begin
    int dones;
    rst = 1'b1;
    s_start = '0;
    for (int k = 0; k < 2; k++) begin s_x[k] = '0; s_y[k] = '0; s_i[k] = '0; end
    @(negedge clk);
    @(negedge clk);
    chk("rst busy", 32'(o_busy), 32'd0);
    chk("rst done", 32'(o_done), 32'd0);
    chk("rst Z", o_z[0] | o_z[1], 32'd0);
    chk("rst Zi", 32'(o_zi), 32'd0);
    rst = 1'b0;

    run_op(0, 32'b1010, 32'd1, 32'd2, 32'h14, 2, 1'b1);
    s_i[0] = 32'd1;
    #1 chk("Zi i=1", 32'(o_zi[0]), 32'd0);
    run_op(0, 32'b1010, 32'd2, 32'd3, 32'h28, 3, 1'b1);
    run_op(0, 32'b1010, 32'd7, 32'd8, 32'h500, 8, 1'b1);
    run_op(0, 32'b1010, 32'd35, 32'd40, 32'h0, 1, 1'b0);
    run_op(0, 32'h8000_0001, 32'd32, 32'd0, 32'h0, 1, 1'b0);
    run_op(0, 32'h8000_0001, 32'd31, 32'd31, 32'h8000_0000, 32, 1'b1);
    run_op(1, 32'hFFFF_FFFF, 32'd7, 32'd7, 32'hFFFF_FF80, 3, 1'b1);
    run_op(1, 32'hFFFF_FFFF, 32'd0, 32'd0, 32'hFFFF_FFFF, 1, 1'b1);
    run_op(1, 32'h0000_0003, 32'd30, 32'd31, 32'hC000_0000, 9, 1'b1);

    // Start re-pulsed while busy must be ignored.
    @(negedge clk);
    s_x[0] = 32'b1010; s_y[0] = 32'd5; s_i[0] = 32'd8; s_start[0] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    s_x[0] = 32'h1; s_y[0] = 32'd3;
    dones = 0;
    for (int c = 0; c < 10; c++) begin
      if (c == 2) s_start[0] = 1'b0;
      if (o_done[0]) begin
        dones++;
        chk("ignore Z", o_z[0], 32'h140);
      end
      @(negedge clk);
    end
    chk("ignore dones", 32'(dones), 32'd1);
    chk("ignore Zhold", o_z[0], 32'h140);

    // Reset in the middle of a long shift aborts without done.
    @(negedge clk);
    s_x[0] = 32'b1010; s_y[0] = 32'd20; s_i[0] = 32'd6; s_start[0] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    s_start[0] = 1'b0;
    repeat (5) @(negedge clk);
    #1 rst = 1'b1;
    #1;
    chk("abort busy", 32'(o_busy[0]), 32'd0);
    chk("abort done", 32'(o_done[0]), 32'd0);
    chk("abort Z", o_z[0], 32'd0);
    @(negedge clk);
    rst = 1'b0;
    dones = 0;
    for (int c = 0; c < 20; c++) begin
      if (o_done[0]) dones++;
      @(negedge clk);
    end
    chk("abort nodone", 32'(dones), 32'd0);
    run_op(0, 32'b1010, 32'd3, 32'd6, 32'h50, 4, 1'b1);

    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/shift_left_logical_seq.md
# shift_left_logical_seq

Multi-cycle 32-bit logical left shifter with a start/done handshake, the left-shift companion to the single-bit right-shift logic in the ALU. It captures an operand and shift amount and shifts by up to STEP bits per clock. It presents a registered result plus a bit-select output, so the ALU control sequencer can trade latency for area.

## Interface
- WIDTH, 32: operand/result width; power of two.
- STEP, 1: maximum bits shifted per cycle; 1..WIDTH.
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  request; sampled only when busy=0.
- X  in  WIDTH  operand, captured with start.
- Y  in  32  shift amount (unsigned, full 32 bits), captured with start.
- i  in  32  bit index into the result for Zi.
- busy  out  1  high from the cycle after acceptance through the done cycle.
- done  out  1  one-cycle pulse; Z valid from this cycle on.
- Z  out  WIDTH  registered result, held until the next accepted start.
- Zi  out  1  Z[i]; 0 when i >= WIDTH; combinational from Z and i.

## Operation
- FSM states: IDLE, SHIFT, DONE.
- IDLE, start=1:
  - Load acc<=X and remaining<=Y.
  - If Y >= WIDTH: acc<=0 and go to DONE (shortcut).
  - Else if Y=0: go to DONE.
  - Else: go to SHIFT.
- SHIFT, each clock:
  - k = min(STEP, remaining).
  - acc <= acc << k, zero fill; bits shifted past MSB are discarded.
  - remaining <= remaining - k.
  - Go to DONE when remaining - k == 0.
- DONE: Z<=acc was loaded on entry; done=1 for this cycle only; unconditionally return to IDLE.
- Z updates only on entry to DONE; between operations it holds the last result.
- busy = (state != IDLE).
- start while busy=1 (including DONE) is ignored; X and Y changes after acceptance have no effect.
- start is level-sampled: holding it high re-issues an operation on the first IDLE cycle after DONE.
- No overflow or flag outputs; the result is purely logical (not arithmetic).

## Timing
- Reset (async assert, sync-released internally by clk edge behaviour): state=IDLE, busy=0, done=0, Z=0, acc=0, remaining=0; Zi therefore 0.
- Reset mid-operation aborts immediately. No done is issued, Z=0.
- Latency, start-sample edge to done-high cycle:
  - 1 cycle when Y=0 or Y >= WIDTH.
  - Otherwise 1 + ceil(Y/STEP) cycles.
  - STEP=1: Y=1 gives 2 cycles; Y=31 gives 32 cycles.
- Throughput: one operation per latency+1 cycles (the IDLE cycle is mandatory between operations).
- done and the new Z value appear in the same cycle. Zi follows Z with no added delay.

## Structure
- Package shift_pkg:
  - state enum {IDLE, SHIFT, DONE};
  - default WIDTH;
  - function min_step(remaining, STEP).
- Sub-module shift_left_step:
  - combinational, acc and k in, acc<<k out;
  - instantiated once; reusable by a future arithmetic variant.
- Top module holds the FSM, the acc/remaining registers and the Z register.

## Test plan
- X=32'b1010, Y=1, STEP=1 -> Z=32'h14; done 2 cycles after start edge; Zi with i=2 is 1, with i=1 is 0.
- X=32'b1010, Y=2 then Y=7 -> Z=32'h28 (latency 3), then Z=32'h500 (latency 8); busy high throughout each.
- X=32'b1010, Y=35; also Y=32 -> Z=0, latency 1, done single-cycle; i=40 gives Zi=0.
- STEP=4, X=32'hFFFF_FFFF, Y=7 -> steps of 4 then 3, Z=32'hFFFF_FF80, latency 3; Y=0 -> Z=X, latency 1.
- Start pulsed again while busy with different X/Y -> ignored; the original result is delivered; exactly one done pulse.
- rst asserted in SHIFT (Y=20, after 5 cycles) -> immediately busy=0, Z=0, no done; the next start operates normally.
